trainer_input_sequencer: RTL and testbench

Input stage of the digital trainer kit. It drives the `a`/`b` operand pair into the basic-gate block. It conditions two raw slide switches and a step push-button by synchronising and debouncing them. It then presents operands in one of three modes: direct switch control, single-step truth-table walk, or free-running truth-table walk.

---
 rtl/trainer_input_sequencer.sv | 126 ++++++++++++
 tb/tb_trainer_input_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/trainer_input_sequencer.sv
// Trainer-kit input stage: synchronises and debounces two switches and a step button,
// then drives the a/b operand pair in manual, single-step or free-running walk mode.
module trainer_input_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STEP_DIV        = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_a,
  input  logic       sw_b,
  input  logic       btn_step,
  input  logic [1:0] mode,
  output logic       a,
  output logic       b,
  output logic       vec_valid,
  output logic       cycle_done
);

  typedef enum logic [1:0] {
    ModeManual    = 2'b00,
    ModeStep      = 2'b01,
    ModeAuto      = 2'b10,
    ModeManualAlt = 2'b11
  } mode_e;

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DivW = $clog2(STEP_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(STEP_DIV - 1);

  // Bit order for the conditioned inputs: [2]=sw_a, [1]=sw_b, [0]=btn_step.
  logic [2:0]      raw;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      stable_q, stable_d;
  logic [CntW-1:0] cnt_q [3];
  logic [CntW-1:0] cnt_d [3];
  logic            btn_prev_q;
  logic            step_ev;

  mode_e           mode_in, mode_q;
  logic [1:0]      idx_q, idx_d;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      ab_q, ab_d;
  logic            adv;
  logic            vec_valid_q, vec_valid_d;
  logic            cycle_done_q, cycle_done_d;

  assign raw     = {sw_a, sw_b, btn_step};
  assign mode_in = mode_e'(mode);
  assign step_ev = stable_q[0] & ~btn_prev_q;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_comb begin
    idx_d        = idx_q;
    div_d        = '0;
    adv          = 1'b0;
    cycle_done_d = 1'b0;
    if (mode_in != mode_q) begin
      // Mode entry restarts the walk; a coinciding step event or terminal count is dropped.
      idx_d = '0;
    end else begin
      unique case (mode_q)
        ModeStep: adv = step_ev;
        ModeAuto: begin
          adv   = (div_q == DivLast);
          div_d = adv ? '0 : div_q + DivW'(1);
        end
        default:  idx_d = '0;
      endcase
    end
    if (adv) begin
      idx_d        = idx_q + 2'd1;
      cycle_done_d = (idx_q == 2'd3);
    end
    ab_d        = (mode_in == ModeStep || mode_in == ModeAuto) ? idx_d
                                                               : {stable_q[2], stable_q[1]};
    vec_valid_d = (ab_d != ab_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      btn_prev_q   <= 1'b0;
      mode_q       <= ModeManual;
      idx_q        <= '0;
      div_q        <= '0;
      ab_q         <= '0;
      vec_valid_q  <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      btn_prev_q   <= stable_q[0];
      mode_q       <= mode_in;
      idx_q        <= idx_d;
      div_q        <= div_d;
      ab_q         <= ab_d;
      vec_valid_q  <= vec_valid_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign a          = ab_q[1];
  assign b          = ab_q[0];
  assign vec_valid  = vec_valid_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_trainer_input_sequencer.sv
// Scoreboard bench for trainer_input_sequencer: a behavioural model predicts every
// vec_valid / cycle_done event; a monitor pops and compares when the DUT presents one.
module tb_trainer_input_sequencer;

  localparam int D  = 4;
  localparam int SD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_a = 1'b0, sw_b = 1'b0, btn_step = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       a, b, vec_valid, cycle_done;

  always #5 clk = ~clk;

  trainer_input_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .STEP_DIV       (SD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_a      (sw_a),
    .sw_b      (sw_b),
    .btn_step  (btn_step),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .vec_valid (vec_valid),
    .cycle_done(cycle_done)
  );

  typedef struct {
    int         cyc;
    logic [1:0] ab;
    logic       vv;
    logic       cd;
  } ev_t;

  ev_t exp_q[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cyc        = 0;
  bit  mon_en     = 0;

  // Model state: raw-sample histories (bit 0 = sample at the previous edge).
  logic [63:0] ha, hb, hk;
  logic        sa, sb, sk, pk;
  logic [1:0]  mq, mab;
  int          idx, elapsed;

  // A debounced value flips once the last D synchronised samples all disagree with it;
  // the synchronised sample seen at edge t-k is the raw sample from edge t-k-2.
  function automatic bit settles(input logic [63:0] h, input logic st);
    for (int i = 1; i <= D; i++) if (h[i] == st) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    ev_t        e;
    logic [1:0] nab;
    bit         adv, cdn;
    cyc++;
    if (rst) begin
      ha = '0; hb = '0; hk = '0;
      sa = 0; sb = 0; sk = 0; pk = 0;
      mq = 2'b00; mab = 2'b00; idx = 0; elapsed = 0;
      return;
    end
    adv = 0;
    cdn = 0;
    if (mode != mq) begin
      idx = 0;
      elapsed = 0;
    end else if (mode == 2'b01) begin
      adv = sk && !pk;
    end else if (mode == 2'b10) begin
      elapsed++;
      adv = (elapsed % SD == 0);
    end else begin
      idx = 0;
    end
    if (adv) begin
      cdn = (idx == 3);
      idx = (idx + 1) % 4;
    end
    nab = (mode == 2'b01 || mode == 2'b10) ? 2'(idx) : {sa, sb};
    if (nab != mab || cdn) begin
      e.cyc = cyc; e.ab = nab; e.vv = (nab != mab); e.cd = cdn;
      exp_q.push_back(e);
    end
    mab = nab;
    mq  = mode;
    pk  = sk;
    if (settles(ha, sa)) sa = ~sa;
    if (settles(hb, sb)) sb = ~sb;
    if (settles(hk, sk)) sk = ~sk;
    ha = {ha[62:0], sw_a};
    hb = {hb[62:0], sw_b};
    hk = {hk[62:0], btn_step};
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          compared++;
          mismatched++;
          $display("FAIL missed_event: at cycle %0d got no event, required ab=%b vv=%b cd=%b",
                   e.cyc, e.ab, e.vv, e.cd);
        end
        if (vec_valid === 1'b1 || cycle_done === 1'b1) begin
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_event: cycle %0d got ab=%b vv=%b cd=%b, required none",
                     cyc, {a, b}, vec_valid, cycle_done);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || {vec_valid, cycle_done, a, b} !== {e.vv, e.cd, e.ab}) begin
              mismatched++;
              $display("FAIL event: cycle %0d got ab=%b vv=%b cd=%b, required cycle %0d ab=%b vv=%b cd=%b",
                       cyc, {a, b}, vec_valid, cycle_done, e.cyc, e.ab, e.vv, e.cd);
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    bit found;
    // Reset with switches high; operands must stay cleared.
    sw_a = 1; sw_b = 1; mode = 2'b00; rst = 1;
    ticks(2);
    check("reset_a", {3'b0, a}, 4'h0);
    check("reset_b", {3'b0, b}, 4'h0);
    check("reset_vec_valid", {3'b0, vec_valid}, 4'h0);
    check("reset_cycle_done", {3'b0, cycle_done}, 4'h0);
    mon_en = 1;
    rst = 0;
    ticks(12);

    // Manual: short pulse and bounces are rejected, a long hold is accepted once.
    sw_a = 0; sw_b = 0; ticks(12);
    sw_a = 1; ticks(3); sw_a = 0; ticks(2);
    sw_a = 1; ticks(1); sw_a = 0; ticks(1); sw_a = 1; ticks(1); sw_a = 0; ticks(8);
    sw_a = 1; ticks(10);

    // Step: five presses, the fourth held long.
    mode = 2'b01; ticks(4);
    for (int p = 0; p < 5; p++) begin
      btn_step = 1; ticks(p == 3 ? 40 : 8);
      btn_step = 0; ticks(8);
    end

    // Auto with the button toggling.
    mode = 2'b10;
    for (int i = 0; i < 70; i++) begin btn_step = ~btn_step; tick(); end
    btn_step = 0;

    // Leave auto for manual at 11, then come back.
    sw_a = 1; sw_b = 1; mode = 2'b00; ticks(12);
    mode = 2'b10; ticks(20);

    // Randomised segments across all modes with occasional reset.
    for (int s = 0; s < 25; s++) begin
      mode = 2'($urandom_range(0, 3));
      for (int i = 0, n = $urandom_range(20, 100); i < n; i++) begin
        if ($urandom_range(0, 9) == 0) sw_a = ~sw_a;
        if ($urandom_range(0, 9) == 0) sw_b = ~sw_b;
        if ($urandom_range(0, 6) == 0) btn_step = ~btn_step;
        rst = ($urandom_range(0, 299) == 0);
        tick();
      end
      rst = 0;
    end

    // Reset landing on a terminal count at ab=11 suppresses cycle_done.
    mode = 2'b10; btn_step = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mq == 2'b10 && mab == 2'b11 && ((elapsed + 1) % SD == 0)) found = 1;
      else tick();
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL reach_terminal: got no terminal count at ab=11 within budget, required one");
    end
    rst = 1; tick();
    check("rst_at_tc_ab", {2'b0, a, b}, 4'h0);
    check("rst_at_tc_vec_valid", {3'b0, vec_valid}, 4'h0);
    check("rst_at_tc_cycle_done", {3'b0, cycle_done}, 4'h0);
    rst = 0; ticks(40);

    mode = 2'b00; ticks(20);
    check("final_ab", {2'b0, a, b}, {2'b0, mab});
    check("queue_drained", (exp_q.size() == 0) ? 4'h0 : 4'h1, 4'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
